// File: rtl/led_fade_pwm_if.sv
// Pattern-side bundle for led_fade_pwm: on/off targets and fade enable in, PWM pins and busy out.
interface led_fade_pwm_if #(
    parameter int CH_NUM = 4
);
    logic [CH_NUM-1:0] led_in;
    logic              fade_en;
    logic [CH_NUM-1:0] led_out;
    logic              busy;

    modport master (output led_in, output fade_en, input led_out, input busy);
    modport slave  (input led_in, input fade_en, output led_out, output busy);
endinterface

// File: rtl/led_fade_pwm.sv
// Per-channel PWM cross-fader: each duty ramps toward FULL or 0 following a registered on/off pattern.
// Optional perceptual curve on the shadow duty is enabled by defining LED_FADE_GAMMA_EN.
module led_fade_pwm #(
    parameter int CH_NUM   = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP_MAX = 97_655,
    parameter int UP_STEP  = 1,
    parameter int DN_STEP  = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    led_fade_pwm_if.slave bus
);
    localparam int STEP_W = (STEP_MAX > 0) ? $clog2(STEP_MAX + 1) : 1;
    localparam logic [PWM_BITS-1:0] FULL     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST = FULL - 1'b1;
    localparam logic [PWM_BITS:0]   UP_EXT   = (PWM_BITS + 1)'(UP_STEP);
    localparam logic [PWM_BITS:0]   DN_EXT   = (PWM_BITS + 1)'(DN_STEP);

    logic [CH_NUM-1:0]   led_in_r_q, led_in_r_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] duty_q     [CH_NUM];
    logic [PWM_BITS-1:0] duty_d     [CH_NUM];
    logic [PWM_BITS-1:0] duty_act_q [CH_NUM];
    logic [PWM_BITS-1:0] duty_act_d [CH_NUM];
    logic [CH_NUM-1:0]   led_out_q, led_out_d;
    logic [CH_NUM-1:0]   mismatch;
    logic                step_tick;
    logic                period_end;

    always_comb begin
        led_in_r_d = bus.led_in;
        period_end = (pwm_cnt_q == PWM_LAST);
        pwm_cnt_d  = period_end ? '0 : pwm_cnt_q + 1'b1;
        step_tick  = bus.fade_en && (step_cnt_q == STEP_W'(STEP_MAX));
        step_cnt_d = step_cnt_q;
        if (bus.fade_en) begin
            step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
        end
    end

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic [PWM_BITS:0]   up_sum;
        logic [PWM_BITS:0]   dn_diff;
        logic [PWM_BITS-1:0] duty_sat;
        logic [PWM_BITS-1:0] duty_shaped;

        // One extra bit of headroom so the saturation test sees overflow/underflow.
        always_comb begin
            up_sum  = {1'b0, duty_q[gi]} + UP_EXT;
            dn_diff = {1'b0, duty_q[gi]} - DN_EXT;
            if (led_in_r_q[gi]) begin
                duty_sat = (up_sum > {1'b0, FULL}) ? FULL : PWM_BITS'(up_sum);
            end else begin
                duty_sat = ({1'b0, duty_q[gi]} < DN_EXT) ? '0 : PWM_BITS'(dn_diff);
            end
        end

`ifdef LED_FADE_GAMMA_EN
        logic [2*PWM_BITS:0] gamma_prod;
        always_comb begin
            gamma_prod  = (2 * PWM_BITS + 1)'(duty_q[gi]) * ((2 * PWM_BITS + 1)'(duty_q[gi]) + 1'b1);
            duty_shaped = PWM_BITS'(gamma_prod >> PWM_BITS);
        end
`else
        always_comb begin
            duty_shaped = duty_q[gi];
        end
`endif

        // Shadow loads the pre-step duty, so a tick on the boundary shows up one period later.
        assign duty_d[gi]     = step_tick ? duty_sat : duty_q[gi];
        assign duty_act_d[gi] = period_end ? duty_shaped : duty_act_q[gi];
        assign led_out_d[gi]  = (duty_act_q[gi] > pwm_cnt_q);
        assign mismatch[gi]   = (duty_q[gi] != (led_in_r_q[gi] ? FULL : '0));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_in_r_q <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            led_out_q  <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            led_in_r_q <= led_in_r_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            led_out_q  <= led_out_d;
            for (int i = 0; i < CH_NUM; i++) begin
                duty_q[i]     <= duty_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign bus.led_out = led_out_q;
    assign bus.busy    = |mismatch;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: two instances (unit steps and steps of 4) against an arithmetic fade model.
module tb_led_fade_pwm;
    localparam int FULL = 15;
    localparam int SMAX = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] led_in_v;
    logic       fade_en_v;

    led_fade_pwm_if #(.CH_NUM(4)) if_a ();
    led_fade_pwm_if #(.CH_NUM(4)) if_b ();

    led_fade_pwm #(.CH_NUM(4), .PWM_BITS(4), .STEP_MAX(SMAX), .UP_STEP(1), .DN_STEP(1)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if_a));
    led_fade_pwm #(.CH_NUM(4), .PWM_BITS(4), .STEP_MAX(SMAX), .UP_STEP(4), .DN_STEP(4)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: duties as integers, PWM phase and step phase derived from cycle counts.
    int         m_duty [2][4];
    int         m_act  [2][4];
    logic [3:0] m_out  [2];
    logic [3:0] m_lin_r;
    int         m_cyc;
    int         m_fe;

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int shape(input int d);
`ifdef LED_FADE_GAMMA_EN
        return (d * (d + 1)) / 16;
`else
        return d;
`endif
    endfunction

    function automatic logic model_busy(input int k);
        logic b = 1'b0;
        for (int ch = 0; ch < 4; ch++)
            if (m_duty[k][ch] != (m_lin_r[ch] ? FULL : 0)) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = '0;
            for (int ch = 0; ch < 4; ch++) begin
                m_duty[k][ch] = 0;
                m_act[k][ch]  = 0;
            end
        end
        m_lin_r = '0;
        m_cyc   = 0;
        m_fe    = 0;
    endtask

    task automatic model_edge();
        bit tick;
        bit pend;
        int phase;
        phase = m_cyc % FULL;
        tick  = fade_en_v && ((m_fe % (SMAX + 1)) == SMAX);
        pend  = (phase == FULL - 1);
        for (int k = 0; k < 2; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                int d;
                d = m_duty[k][ch];
                m_out[k][ch] = (m_act[k][ch] > phase);
                if (pend) m_act[k][ch] = shape(d);
                if (tick) begin
                    if (m_lin_r[ch]) m_duty[k][ch] = (d + step_of(k) > FULL) ? FULL : d + step_of(k);
                    else             m_duty[k][ch] = (d - step_of(k) < 0) ? 0 : d - step_of(k);
                end
            end
        end
        m_lin_r = led_in_v;
        m_cyc++;
        if (fade_en_v) m_fe++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk($sformatf("a led_out c%0d", m_cyc), 32'(if_a.led_out), 32'(m_out[0]));
        chk($sformatf("b led_out c%0d", m_cyc), 32'(if_b.led_out), 32'(m_out[1]));
        chk($sformatf("a busy c%0d", m_cyc), 32'(if_a.busy), 32'(model_busy(0)));
        chk($sformatf("b busy c%0d", m_cyc), 32'(if_b.busy), 32'(model_busy(1)));
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("a duty%0d c%0d", ch, m_cyc), 32'(dut_a.duty_q[ch]), 32'(m_duty[0][ch]));
            chk($sformatf("b duty%0d c%0d", ch, m_cyc), 32'(dut_b.duty_q[ch]), 32'(m_duty[1][ch]));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [3:0] led, input logic fe);
        led_in_v     = led;
        fade_en_v    = fe;
        if_a.led_in  = led;
        if_a.fade_en = fe;
        if_b.led_in  = led;
        if_b.fade_en = fe;
    endtask

    task automatic wait_duty(input int target, input string tag);
        int n;
        n = 0;
        while (m_duty[0][0] != target && n < 400) begin
            cyc();
            n++;
        end
        chk({tag, " reached in budget"}, 32'(n < 400), 32'd1);
    endtask

    task automatic count_high(input int k, output int hi);
        hi = 0;
        repeat (FULL) begin
            cyc();
            hi += (k == 0) ? int'(if_a.led_out[0]) : int'(if_b.led_out[0]);
        end
    endtask

    initial begin
        int hi;
        rst_n = 1'b1;
        set_in(4'b0000, 1'b1);
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("reset a led_out", 32'(if_a.led_out), 32'd0);
        chk("reset a busy", 32'(if_a.busy), 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (6) cyc();
        chk("idle a led_out", 32'(if_a.led_out), 32'd0);
        chk("idle b busy", 32'(if_b.busy), 32'd0);

        // Fade channel 0 in; busy follows one cycle after led_in.
        set_in(4'b0001, 1'b1);
        chk("busy before register", 32'(if_a.busy), 32'd0);
        cyc();
        chk("busy rise", 32'(if_a.busy), 32'd1);
        wait_duty(FULL, "rise to full");
        repeat (2 * FULL) cyc();
        count_high(0, hi);
        chk("a full high count", 32'(hi), 32'(FULL));
        count_high(1, hi);
        chk("b full high count", 32'(hi), 32'(FULL));
        chk("a upper ch off", 32'(if_a.led_out[3:1]), 32'd0);
        chk("a busy at full", 32'(if_a.busy), 32'd0);

        // Back to zero, then reverse direction mid-fade at duty 7.
        set_in(4'b0000, 1'b1);
        wait_duty(0, "fall to zero");
        set_in(4'b0001, 1'b1);
        wait_duty(7, "rise to 7");
        set_in(4'b0000, 1'b1);
        wait_duty(6, "reverse step");
        chk("reverse duty", 32'(dut_a.duty_q[0]), 32'd6);
        wait_duty(0, "reverse to zero");
        repeat (2 * FULL) cyc();
        count_high(0, hi);
        chk("a off high count", 32'(hi), 32'd0);
        chk("a busy at zero", 32'(if_a.busy), 32'd0);

        // Freeze at 5, then at 7, and measure the steady high time.
        set_in(4'b0001, 1'b1);
        wait_duty(5, "rise to 5");
        set_in(4'b0001, 1'b0);
        repeat (2 * FULL) cyc();
        chk("frozen duty 5", 32'(dut_a.duty_q[0]), 32'd5);
        count_high(0, hi);
        chk("duty5 high count", 32'(hi), 32'(shape(5)));
        set_in(4'b0001, 1'b1);
        wait_duty(7, "rise to 7 again");
        set_in(4'b0001, 1'b0);
        repeat (2 * FULL) cyc();
        count_high(0, hi);
        chk("duty7 high count", 32'(hi), 32'(shape(7)));

        // Random pattern changes and enable gaps.
        for (int s = 0; s < 24; s++) begin
            set_in(4'($urandom), ($urandom_range(0, 3) != 0));
            repeat ($urandom_range(1, 25)) cyc();
        end

        // Asynchronous reset pulse between clock edges mid-fade.
        set_in(4'b1111, 1'b1);
        repeat (22) cyc();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async a led_out", 32'(if_a.led_out), 32'd0);
        chk("async b led_out", 32'(if_b.led_out), 32'd0);
        chk("async a busy", 32'(if_a.busy), 32'd0);
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("async a duty%0d", ch), 32'(dut_a.duty_q[ch]), 32'd0);
            chk($sformatf("async b duty%0d", ch), 32'(dut_b.duty_q[ch]), 32'd0);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (90) cyc();
        count_high(0, hi);
        chk("after reset full high count", 32'(hi), 32'(FULL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
